// File: rtl/pio_pkg.sv
// Shared definitions for the Avalon-MM PIO bank:
// register offsets, edge modes and the edge detector.
package pio_pkg;

    localparam logic [2:0] REG_DATA_OUT = 3'd0;
    localparam logic [2:0] REG_DATA_IN  = 3'd1;
    localparam logic [2:0] REG_IRQ_MASK = 3'd2;
    localparam logic [2:0] REG_EDGE_CAP = 3'd3;
    localparam logic [2:0] REG_OUT_SET  = 3'd4;
    localparam logic [2:0] REG_OUT_CLR  = 3'd5;

    typedef enum logic [1:0] {
        EDGE_RISE = 2'd0,
        EDGE_FALL = 2'd1,
        EDGE_ANY  = 2'd2
    } edge_mode_e;

    function automatic logic [31:0] edge_detect(
        input logic [31:0] cur,
        input logic [31:0] prev,
        input edge_mode_e  mode
    );
        case (mode)
            EDGE_RISE: return cur & ~prev;
            EDGE_FALL: return ~cur & prev;
            default:   return cur ^ prev;
        endcase
    endfunction

endpackage

// File: rtl/pio_channel.sv
// One PIO channel: output register with set/clear, input synchroniser,
// sticky edge capture, interrupt mask and register read mux.
module pio_channel
    import pio_pkg::*;
#(
    parameter int              OUT_W       = 16,
    parameter int              IN_W        = 2,
    parameter int              SYNC_STAGES = 2,
    parameter int              EDGE_MODE   = 0,
    parameter logic [OUT_W-1:0] OUT_RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr,
    input  logic [2:0]       reg_sel,
    input  logic [31:0]      wdata,
    input  logic             edge_en,
    input  logic [IN_W-1:0]  pin,
    output logic [OUT_W-1:0] out_val,
    output logic [31:0]      rdata,
    output logic             irq_pend
);

    localparam int         LAST = SYNC_STAGES - 1;
    localparam edge_mode_e MODE = edge_mode_e'(EDGE_MODE);

    logic [OUT_W-1:0] out_q;
    logic [OUT_W-1:0] out_next;
    logic [IN_W-1:0]  sync_q [SYNC_STAGES];
    logic [IN_W-1:0]  prev_q;
    logic [IN_W-1:0]  mask_q;
    logic [IN_W-1:0]  cap_q;
    logic [IN_W-1:0]  cap_clr;
    logic [IN_W-1:0]  edges;
    logic [IN_W-1:0]  cap_next;
    logic [31:0]      edge_vec;
    logic [OUT_W-1:0] w_out;
    logic [IN_W-1:0]  w_in;
    logic             unused_bits;

    assign w_out       = wdata[OUT_W-1:0];
    assign w_in        = wdata[IN_W-1:0];
    assign unused_bits = ^{wdata, edge_vec};

    always_comb begin
        out_next = out_q;
        if (wr) begin
            case (reg_sel)
                REG_DATA_OUT: out_next = w_out;
                REG_OUT_SET:  out_next = out_q | w_out;
                REG_OUT_CLR:  out_next = out_q & ~w_out;
                default:      out_next = out_q;
            endcase
        end
    end

    assign edge_vec = edge_detect(32'(sync_q[LAST]), 32'(prev_q), MODE);
    assign edges    = edge_en ? edge_vec[IN_W-1:0] : '0;
    assign cap_clr  = (wr && reg_sel == REG_EDGE_CAP) ? w_in : '0;
    // a new edge wins over a same-cycle write-1-to-clear
    assign cap_next = (cap_q & ~cap_clr) | edges;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q  <= OUT_RST_VAL;
            prev_q <= '0;
            mask_q <= '0;
            cap_q  <= '0;
            for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
        end else begin
            out_q     <= out_next;
            sync_q[0] <= pin;
            for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
            prev_q    <= sync_q[LAST];
            cap_q     <= cap_next;
            if (wr && reg_sel == REG_IRQ_MASK) mask_q <= w_in;
        end
    end

    always_comb begin
        rdata = '0;
        case (reg_sel)
            REG_DATA_OUT: rdata = 32'(out_q);
            REG_DATA_IN:  rdata = 32'(sync_q[LAST]);
            REG_IRQ_MASK: rdata = 32'(mask_q);
            REG_EDGE_CAP: rdata = 32'(cap_q);
            default:      rdata = '0;
        endcase
    end

    assign out_val  = out_q;
    assign irq_pend = |(cap_q & mask_q);

endmodule

// File: rtl/avalon_pio_bank.sv
// Multi-channel Avalon-MM PIO bank: address decode, registered read data,
// post-reset edge warm-up and the registered interrupt line.
module avalon_pio_bank
    import pio_pkg::*;
#(
    parameter int               NUM_CH      = 4,
    parameter int               OUT_W       = 16,
    parameter int               IN_W        = 2,
    parameter int               SYNC_STAGES = 2,
    parameter int               EDGE_MODE   = 0,
    parameter logic [OUT_W-1:0] OUT_RST_VAL = '0
) (
    input  logic                        clk_clk,
    input  logic                        reset_reset,
    input  logic [$clog2(NUM_CH)+2:0]   avs_address,
    input  logic                        avs_read,
    input  logic                        avs_write,
    input  logic [31:0]                 avs_writedata,
    output logic [31:0]                 avs_readdata,
    output logic [NUM_CH*OUT_W-1:0]     pio_out_export,
    input  logic [NUM_CH*IN_W-1:0]      pio_in_export,
    output logic                        irq
);

    localparam int         CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [2:0] WARM = 3'(SYNC_STAGES + 1);

    logic [CH_W-1:0]   ch;
    logic              ch_ok;
    logic [2:0]        reg_sel;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] pend;
    logic [31:0]       rdata [NUM_CH];
    logic [31:0]       rd_sel;
    logic [2:0]        warm_q;
    logic              edge_en;

    if (NUM_CH > 1) begin : g_ch_addr
        assign ch = avs_address[$clog2(NUM_CH)+2:3];
    end else begin : g_ch_single
        assign ch = '0;
    end

    assign reg_sel = avs_address[2:0];
    assign ch_ok   = int'(ch) < NUM_CH;

    always_comb begin
        wr_sel = '0;
        rd_sel = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (ch_ok && int'(ch) == c) begin
                wr_sel[c] = avs_write;
                rd_sel    = rdata[c];
            end
        end
    end

    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        pio_channel #(
            .OUT_W       (OUT_W),
            .IN_W        (IN_W),
            .SYNC_STAGES (SYNC_STAGES),
            .EDGE_MODE   (EDGE_MODE),
            .OUT_RST_VAL (OUT_RST_VAL)
        ) u_ch (
            .clk      (clk_clk),
            .rst      (reset_reset),
            .wr       (wr_sel[c]),
            .reg_sel  (reg_sel),
            .wdata    (avs_writedata),
            .edge_en  (edge_en),
            .pin      (pio_in_export[c*IN_W +: IN_W]),
            .out_val  (pio_out_export[c*OUT_W +: OUT_W]),
            .rdata    (rdata[c]),
            .irq_pend (pend[c])
        );
    end

    // read returns the pre-write value when a write shares the cycle
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            avs_readdata <= '0;
        end else if (avs_read) begin
            avs_readdata <= rd_sel;
        end
    end

    // hold off edges until the sync chain and its delayed copy hold real pin data
    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            warm_q <= '0;
        end else if (warm_q != WARM) begin
            warm_q <= warm_q + 3'd1;
        end
    end

    assign edge_en = (warm_q == WARM);

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            irq <= 1'b0;
        end else begin
            irq <= |pend;
        end
    end

endmodule
